ctrl_pipe: RTL and testbench

Pipelined main control unit for the 5-stage core. It decodes the D-stage instruction into a control word and carries that word through the E/M/W control registers. It also owns hazard control: i-cache/d-cache miss stalls, load-use interlock, branch/jump redirect flush, and a parametrised multi-cycle MUL hold. The datapath consumes its stall/flush outputs and per-stage control bits.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/ctrl_stage_reg.sv | 37 +++
 rtl/ctrl_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode constants and the pipelined control word for ctrl_pipe.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       load;
    logic       branch;
    logic       jump;
    logic       byte_sel;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] aluop;
    logic       mul;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;
  localparam int    CTRL_W   = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_stage_reg.sv
// Pipeline control register with hold and clear-to-NOP; a bubble wins over a load.
module ctrl_stage_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (bubble) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Main control unit: D-stage decode, E/M/W control registers and hazard control.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter bit          EN_MUL  = 1'b1,
  parameter int          RW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ihit,
  input  logic          dhit,
  input  logic [6:0]    opcode,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [RW-1:0] rs1_d,
  input  logic [RW-1:0] rs2_d,
  input  logic [RW-1:0] rd_d,
  input  logic          zero_e,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_d,
  output logic          redirect_e,
  output logic          alu_src_e,
  output logic [1:0]    aluop_e,
  output logic          mul_e,
  output logic          mem_write_m,
  output logic          byte_m,
  output logic          reg_write_w,
  output logic          mem_to_reg_w,
  output logic          byte_w,
  output logic [RW-1:0] rd_w,
  output logic          illegal_d
);

  localparam int          SW           = CTRL_W + RW;
  localparam logic [3:0]  MUL_CNT_INIT = 4'(MUL_LAT - 1);

  ctrl_t          dec_ctrl_s, ctrl_e_s, ctrl_m_s, ctrl_w_s;
  logic           dec_illegal_s;
  logic [RW-1:0]  rd_e_s;
  logic [SW-1:0]  e_out_s, m_out_s, w_out_s;
  logic           mul_busy_s, redirect_s, load_use_s, mul_enter_s;
  logic           stall_f_s, stall_d_s, flush_d_s;
  logic           en_e_s, bub_e_s, en_m_s, bub_m_s, en_w_s;
  logic [3:0]     mul_cnt_q, mul_cnt_d;
  logic           unused_ok_s;

  always_comb begin
    dec_ctrl_s    = CTRL_NOP;
    dec_illegal_s = 1'b0;
    if (!ihit) begin
      dec_ctrl_s    = CTRL_NOP;
      dec_illegal_s = 1'b0;
    end else begin
      case (opcode)
        OP_LOAD: begin
          if ((funct3 == F3_BYTE) || (funct3 == F3_WORD)) begin
            dec_ctrl_s.reg_write  = 1'b1;
            dec_ctrl_s.load       = 1'b1;
            dec_ctrl_s.alu_src    = 1'b1;
            dec_ctrl_s.mem_to_reg = 1'b1;
            dec_ctrl_s.byte_sel   = (funct3 == F3_BYTE);
          end else begin
            dec_illegal_s = 1'b1;
          end
        end
        OP_STORE: begin
          if ((funct3 == F3_BYTE) || (funct3 == F3_WORD)) begin
            dec_ctrl_s.mem_write = 1'b1;
            dec_ctrl_s.alu_src   = 1'b1;
            dec_ctrl_s.byte_sel  = (funct3 == F3_BYTE);
          end else begin
            dec_illegal_s = 1'b1;
          end
        end
        OP_BRANCH: begin
          if (funct3 == F3_BEQ) begin
            dec_ctrl_s.branch = 1'b1;
            dec_ctrl_s.aluop  = ALUOP_SUB;
          end else begin
            dec_illegal_s = 1'b1;
          end
        end
        OP_JALR: begin
          if (funct3 == F3_JALR) begin
            dec_ctrl_s.jump      = 1'b1;
            dec_ctrl_s.reg_write = 1'b1;
            dec_ctrl_s.alu_src   = 1'b1;
            dec_ctrl_s.aluop     = ALUOP_ADD;
          end else begin
            dec_illegal_s = 1'b1;
          end
        end
        OP_RTYPE: begin
          if ((funct3 == F3_ADD) && ((funct7 == F7_ADD) || (funct7 == F7_SUB))) begin
            dec_ctrl_s.reg_write = 1'b1;
            dec_ctrl_s.aluop     = ALUOP_RTYPE;
          end else if ((funct3 == F3_ADD) && (funct7 == F7_MUL) && (EN_MUL == 1'b1)) begin
            dec_ctrl_s.reg_write = 1'b1;
            dec_ctrl_s.aluop     = ALUOP_RTYPE;
            dec_ctrl_s.mul       = 1'b1;
          end else begin
            dec_illegal_s = 1'b1;
          end
        end
        default: dec_illegal_s = 1'b1;
      endcase
    end
  end

  assign {ctrl_e_s, rd_e_s} = e_out_s;
  assign ctrl_m_s           = m_out_s[SW-1 -: CTRL_W];
  assign ctrl_w_s           = w_out_s[SW-1 -: CTRL_W];

  assign mul_busy_s = ctrl_e_s.mul & (mul_cnt_q != 4'd0);
  assign redirect_s = (ctrl_e_s.branch & zero_e) | ctrl_e_s.jump;
  assign load_use_s = ctrl_e_s.load & (rd_e_s != '0) &
                      ((rd_e_s == rs1_d) | (rd_e_s == rs2_d));

  // Hazard priority: d-miss freeze, MUL hold, redirect, load-use, i-miss.
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    flush_d_s = 1'b0;
    en_e_s    = 1'b1;
    bub_e_s   = 1'b0;
    en_m_s    = 1'b1;
    bub_m_s   = 1'b0;
    en_w_s    = 1'b1;
    if (!dhit) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      en_e_s    = 1'b0;
      en_m_s    = 1'b0;
      en_w_s    = 1'b0;
    end else if (mul_busy_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      en_e_s    = 1'b0;
      bub_m_s   = 1'b1;
    end else if (redirect_s) begin
      flush_d_s = 1'b1;
      bub_e_s   = 1'b1;
    end else if (load_use_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      bub_e_s   = 1'b1;
    end else if (!ihit) begin
      stall_f_s = 1'b1;
    end else begin
      stall_f_s = 1'b0;
    end
  end

  assign mul_enter_s = en_e_s & ~bub_e_s & dec_ctrl_s.mul;

  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (!dhit) begin
      mul_cnt_d = mul_cnt_q;
    end else if (mul_enter_s) begin
      mul_cnt_d = MUL_CNT_INIT;
    end else if (mul_cnt_q != 4'd0) begin
      mul_cnt_d = mul_cnt_q - 4'd1;
    end else begin
      mul_cnt_d = mul_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_cnt_q <= 4'd0;
    end else begin
      mul_cnt_q <= mul_cnt_d;
    end
  end

  ctrl_stage_reg #(.W(SW)) u_reg_e (
    .clk(clk), .rst_n(reset), .en(en_e_s), .bubble(bub_e_s),
    .d({dec_ctrl_s, rd_d}), .q(e_out_s)
  );
  ctrl_stage_reg #(.W(SW)) u_reg_m (
    .clk(clk), .rst_n(reset), .en(en_m_s), .bubble(bub_m_s),
    .d(e_out_s), .q(m_out_s)
  );
  ctrl_stage_reg #(.W(SW)) u_reg_w (
    .clk(clk), .rst_n(reset), .en(en_w_s), .bubble(1'b0),
    .d(m_out_s), .q(w_out_s)
  );

  assign stall_f      = stall_f_s;
  assign stall_d      = stall_d_s;
  assign flush_d      = flush_d_s;
  assign redirect_e   = redirect_s;
  assign illegal_d    = dec_illegal_s;
  assign alu_src_e    = ctrl_e_s.alu_src;
  assign aluop_e      = ctrl_e_s.aluop;
  assign mul_e        = ctrl_e_s.mul;
  assign mem_write_m  = ctrl_m_s.mem_write;
  assign byte_m       = ctrl_m_s.byte_sel;
  assign reg_write_w  = ctrl_w_s.reg_write;
  assign mem_to_reg_w = ctrl_w_s.mem_to_reg;
  assign byte_w       = ctrl_w_s.byte_sel;
  assign rd_w         = w_out_s[RW-1:0];

  // Control bits that later stages carry but this block does not drive out.
  assign unused_ok_s = ^{ctrl_e_s, ctrl_m_s, ctrl_w_s, m_out_s[RW-1:0]};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: instance 0 default, 1 with MUL_LAT=1, 2 with EN_MUL=0.
module tb_ctrl_pipe;

  logic       clk;
  logic       rst_n;
  logic       ihit, dhit, zero_e;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1_d, rs2_d, rd_d;

  wire [2:0]      stall_f_v, stall_d_v, flush_d_v, redirect_e_v, alu_src_e_v, mul_e_v;
  wire [2:0]      mem_write_m_v, byte_m_v, reg_write_w_v, mem_to_reg_w_v, byte_w_v, illegal_d_v;
  wire [2:0][1:0] aluop_e_v;
  wire [2:0][4:0] rd_w_v;

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ctrl_pipe #(
      .MUL_LAT((g == 1) ? 1 : 3),
      .EN_MUL ((g == 2) ? 1'b0 : 1'b1),
      .RW     (5)
    ) u_dut (
      .clk(clk), .reset(rst_n), .ihit(ihit), .dhit(dhit),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .zero_e(zero_e),
      .stall_f(stall_f_v[g]), .stall_d(stall_d_v[g]), .flush_d(flush_d_v[g]),
      .redirect_e(redirect_e_v[g]), .alu_src_e(alu_src_e_v[g]), .aluop_e(aluop_e_v[g]),
      .mul_e(mul_e_v[g]), .mem_write_m(mem_write_m_v[g]), .byte_m(byte_m_v[g]),
      .reg_write_w(reg_write_w_v[g]), .mem_to_reg_w(mem_to_reg_w_v[g]),
      .byte_w(byte_w_v[g]), .rd_w(rd_w_v[g]), .illegal_d(illegal_d_v[g])
    );
  end

  wire [13:0] regs0 = {alu_src_e_v[0], aluop_e_v[0], mul_e_v[0], mem_write_m_v[0], byte_m_v[0],
                       reg_write_w_v[0], mem_to_reg_w_v[0], byte_w_v[0], rd_w_v[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    ihit = 1'b1; opcode = op; funct3 = f3; funct7 = f7; rd_d = rd; rs1_d = r1; rs2_d = r2;
  endtask

  task automatic idle();
    ihit = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; rd_d = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
  endtask

  task automatic drain();
    idle(); zero_e = 1'b0; dhit = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    idle(); dhit = 1'b1; zero_e = 1'b0; rst_n = 1'b0;
    #3;
    tests++; if (regs0 !== 14'd0) begin fails++; $display("FAIL rst_regs: got %h expected 0", regs0); end
    repeat (2) tick();
    tests++; if (regs0 !== 14'd0) begin fails++; $display("FAIL rst_hold: got %h expected 0", regs0); end
    tests++; if (illegal_d_v[0] !== 1'b0) begin fails++; $display("FAIL rst_illegal: got %b expected 0", illegal_d_v[0]); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    drain();
    drive(7'b0000011, 3'b010, 7'd0, 5'd5, 5'd1, 5'd0);
    #1;
    tests++; if (stall_d_v[0] !== 1'b0) begin fails++; $display("FAIL lu_pre: got %b expected 0", stall_d_v[0]); end
    tick();
    drive(7'b0110011, 3'b000, 7'd0, 5'd6, 5'd5, 5'd1);
    #1;
    tests++; if (stall_d_v[0] !== 1'b1 || stall_f_v[0] !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b%b expected 11", stall_f_v[0], stall_d_v[0]); end
    tick();
    tests++; if (stall_d_v[0] !== 1'b0) begin fails++; $display("FAIL lu_once: got %b expected 0", stall_d_v[0]); end
    tick();
    tests++; if (mem_to_reg_w_v[0] !== 1'b1 || rd_w_v[0] !== 5'd5) begin fails++; $display("FAIL lu_lw_w: got m2r=%b rd=%0d expected 1/5", mem_to_reg_w_v[0], rd_w_v[0]); end
    idle();
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b0) begin fails++; $display("FAIL lu_bubble: got %b expected 0", reg_write_w_v[0]); end
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b1 || rd_w_v[0] !== 5'd6) begin fails++; $display("FAIL lu_add_w: got rw=%b rd=%0d expected 1/6", reg_write_w_v[0], rd_w_v[0]); end
  endtask

  task automatic test_branch();
    drain();
    drive(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2);
    zero_e = 1'b1;
    tick();
    drive(7'b0110011, 3'b000, 7'd0, 5'd7, 5'd3, 5'd4);
    #1;
    tests++; if (redirect_e_v[0] !== 1'b1 || flush_d_v[0] !== 1'b1 || stall_d_v[0] !== 1'b0) begin fails++; $display("FAIL br_taken: got redir=%b flush=%b stall=%b expected 1/1/0", redirect_e_v[0], flush_d_v[0], stall_d_v[0]); end
    tick();
    idle(); zero_e = 1'b0;
    #1;
    tests++; if (redirect_e_v[0] !== 1'b0) begin fails++; $display("FAIL br_after: got %b expected 0", redirect_e_v[0]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (reg_write_w_v[0] !== 1'b0) begin fails++; $display("FAIL br_nop_w%0d: got %b expected 0", i, reg_write_w_v[0]); end
    end
    drain();
    drive(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2);
    tick();
    drive(7'b0110011, 3'b000, 7'd0, 5'd7, 5'd3, 5'd4);
    #1;
    tests++; if (redirect_e_v[0] !== 1'b0 || flush_d_v[0] !== 1'b0) begin fails++; $display("FAIL br_nottaken: got redir=%b flush=%b expected 0/0", redirect_e_v[0], flush_d_v[0]); end
    tick();
    idle();
    repeat (2) tick();
    tests++; if (reg_write_w_v[0] !== 1'b1 || rd_w_v[0] !== 5'd7) begin fails++; $display("FAIL br_fall_w: got rw=%b rd=%0d expected 1/7", reg_write_w_v[0], rd_w_v[0]); end
    drain();
    drive(7'b1100111, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0);
    tick();
    idle();
    #1;
    tests++; if (redirect_e_v[0] !== 1'b1 || alu_src_e_v[0] !== 1'b1) begin fails++; $display("FAIL jalr_redir: got redir=%b alu_src=%b expected 1/1", redirect_e_v[0], alu_src_e_v[0]); end
  endtask

  task automatic test_mul();
    drain();
    drive(7'b0110011, 3'b000, 7'b0000001, 5'd9, 5'd1, 5'd2);
    #1;
    tests++; if (illegal_d_v[0] !== 1'b0 || illegal_d_v[2] !== 1'b1) begin fails++; $display("FAIL mul_illegal: got en=%b dis=%b expected 0/1", illegal_d_v[0], illegal_d_v[2]); end
    tick();
    drive(7'b0110011, 3'b000, 7'd0, 5'd10, 5'd3, 5'd4);
    #1;
    tests++; if (mul_e_v[0] !== 1'b1 || aluop_e_v[0] !== 2'b10 || stall_d_v[0] !== 1'b1) begin fails++; $display("FAIL mul_e1: got mul=%b aluop=%b stall=%b expected 1/10/1", mul_e_v[0], aluop_e_v[0], stall_d_v[0]); end
    tests++; if (stall_d_v[1] !== 1'b0) begin fails++; $display("FAIL mul_lat1_stall: got %b expected 0", stall_d_v[1]); end
    tests++; if (mul_e_v[2] !== 1'b0) begin fails++; $display("FAIL mul_dis_e: got %b expected 0", mul_e_v[2]); end
    tick();
    tests++; if (stall_d_v[0] !== 1'b1) begin fails++; $display("FAIL mul_e2: got %b expected 1", stall_d_v[0]); end
    tick();
    tests++; if (stall_d_v[0] !== 1'b0 || reg_write_w_v[0] !== 1'b0) begin fails++; $display("FAIL mul_e3: got stall=%b rw=%b expected 0/0", stall_d_v[0], reg_write_w_v[0]); end
    tests++; if (reg_write_w_v[1] !== 1'b1 || rd_w_v[1] !== 5'd9) begin fails++; $display("FAIL mul_lat1_w: got rw=%b rd=%0d expected 1/9", reg_write_w_v[1], rd_w_v[1]); end
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b0) begin fails++; $display("FAIL mul_bubble2: got %b expected 0", reg_write_w_v[0]); end
    idle();
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b1 || rd_w_v[0] !== 5'd9) begin fails++; $display("FAIL mul_w: got rw=%b rd=%0d expected 1/9", reg_write_w_v[0], rd_w_v[0]); end
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b1 || rd_w_v[0] !== 5'd10) begin fails++; $display("FAIL mul_next_w: got rw=%b rd=%0d expected 1/10", reg_write_w_v[0], rd_w_v[0]); end
  endtask

  task automatic test_dhit();
    drain();
    drive(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2);
    tick();
    drive(7'b0110011, 3'b000, 7'b0000001, 5'd11, 5'd3, 5'd4);
    tick();
    idle(); dhit = 1'b0;
    #1;
    tests++; if (mem_write_m_v[0] !== 1'b1 || mul_e_v[0] !== 1'b1 || stall_f_v[0] !== 1'b1 || stall_d_v[0] !== 1'b1) begin fails++; $display("FAIL dh_start: got mw=%b mul=%b sf=%b sd=%b expected 1111", mem_write_m_v[0], mul_e_v[0], stall_f_v[0], stall_d_v[0]); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (mem_write_m_v[0] !== 1'b1 || mul_e_v[0] !== 1'b1) begin fails++; $display("FAIL dh_freeze%0d: got mw=%b mul=%b expected 1/1", i, mem_write_m_v[0], mul_e_v[0]); end
    end
    dhit = 1'b1;
    #1;
    tests++; if (stall_d_v[0] !== 1'b1) begin fails++; $display("FAIL dh_cnt2: got %b expected 1", stall_d_v[0]); end
    tick();
    tests++; if (stall_d_v[0] !== 1'b1 || mem_write_m_v[0] !== 1'b0) begin fails++; $display("FAIL dh_cnt1: got stall=%b mw=%b expected 1/0", stall_d_v[0], mem_write_m_v[0]); end
    tick();
    tests++; if (stall_d_v[0] !== 1'b0) begin fails++; $display("FAIL dh_cnt0: got %b expected 0", stall_d_v[0]); end
    repeat (2) tick();
    tests++; if (reg_write_w_v[0] !== 1'b1 || rd_w_v[0] !== 5'd11) begin fails++; $display("FAIL dh_mul_w: got rw=%b rd=%0d expected 1/11", reg_write_w_v[0], rd_w_v[0]); end
  endtask

  task automatic test_ihit();
    drain();
    drive(7'b0110011, 3'b000, 7'b0100000, 5'd12, 5'd1, 5'd2);
    tick();
    ihit = 1'b0; opcode = 7'b0010011; rd_d = 5'd13;
    #1;
    tests++; if (stall_f_v[0] !== 1'b1 || stall_d_v[0] !== 1'b0 || illegal_d_v[0] !== 1'b0) begin fails++; $display("FAIL ih_miss: got sf=%b sd=%b ill=%b expected 1/0/0", stall_f_v[0], stall_d_v[0], illegal_d_v[0]); end
    tick();
    tests++; if (stall_f_v[0] !== 1'b1) begin fails++; $display("FAIL ih_miss2: got %b expected 1", stall_f_v[0]); end
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b1 || rd_w_v[0] !== 5'd12) begin fails++; $display("FAIL ih_sub_w: got rw=%b rd=%0d expected 1/12", reg_write_w_v[0], rd_w_v[0]); end
    drive(7'b0110011, 3'b000, 7'd0, 5'd13, 5'd1, 5'd2);
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b0) begin fails++; $display("FAIL ih_nop_w1: got %b expected 0", reg_write_w_v[0]); end
    drive(7'b0010011, 3'b000, 7'd0, 5'd14, 5'd1, 5'd0);
    #1;
    tests++; if (illegal_d_v[0] !== 1'b1) begin fails++; $display("FAIL ill_opimm: got %b expected 1", illegal_d_v[0]); end
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b0) begin fails++; $display("FAIL ih_nop_w2: got %b expected 0", reg_write_w_v[0]); end
    drive(7'b0000011, 3'b001, 7'd0, 5'd14, 5'd1, 5'd0);
    #1;
    tests++; if (illegal_d_v[0] !== 1'b1) begin fails++; $display("FAIL ill_lh: got %b expected 1", illegal_d_v[0]); end
    idle();
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b1 || rd_w_v[0] !== 5'd13) begin fails++; $display("FAIL ih_add_w: got rw=%b rd=%0d expected 1/13", reg_write_w_v[0], rd_w_v[0]); end
    tick();
    tests++; if (reg_write_w_v[0] !== 1'b0) begin fails++; $display("FAIL ill_nop_w: got %b expected 0", reg_write_w_v[0]); end
  endtask

  task automatic test_reset_mid_mul();
    drain();
    drive(7'b0110011, 3'b000, 7'b0000001, 5'd14, 5'd1, 5'd2);
    tick();
    idle();
    #1;
    tests++; if (stall_d_v[0] !== 1'b1) begin fails++; $display("FAIL rm_busy: got %b expected 1", stall_d_v[0]); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (regs0 !== 14'd0 || stall_d_v[0] !== 1'b0) begin fails++; $display("FAIL rm_clear: got regs=%h stall=%b expected 0/0", regs0, stall_d_v[0]); end
    tick();
    rst_n = 1'b1;
    drive(7'b0000011, 3'b000, 7'd0, 5'd15, 5'd1, 5'd0);
    tick();
    idle();
    repeat (2) tick();
    tests++; if (byte_w_v[0] !== 1'b1 || mem_to_reg_w_v[0] !== 1'b1 || rd_w_v[0] !== 5'd15) begin fails++; $display("FAIL rm_lb_w: got byte=%b m2r=%b rd=%0d expected 1/1/15", byte_w_v[0], mem_to_reg_w_v[0], rd_w_v[0]); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_dhit();
    test_ihit();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
